ace_snoop_responder: RTL and testbench
======================================

Name: ace_snoop_responder

Overview:
- Cached-master side of the ACE snoop channels: accepts AC snoop requests from the coherency unit, looks up the local cache tag/state array, and returns the CR response.
- Returns line data on CD when required, then issues one state-update command to the cache.
- Processes one snoop at a time, in order; sits between the interconnect snoop port and the L1 controller.

Parameters:
- AddrWidth, 64, AC address width
- DataWidth, 64, CD data width
- LineBeats, 4, CD beats per cache line (power of two, >=1)
- snoop_req_t, logic, ACE snoop request struct: ac_valid, ac{addr,prot,snoop}, cr_ready, cd_ready
- snoop_resp_t, logic, ACE snoop response struct: ac_ready, cr_valid, cr_resp[4:0], cd_valid, cd{data,last}

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- snoop_req_i  in  snoop_req_t  snoop request and CR/CD readies from the interconnect
- snoop_resp_o  out  snoop_resp_t  AC ready, CR response, CD data
- lkp_req_o  out  1  cache lookup request
- lkp_addr_o  out  AddrWidth  lookup address (captured ac.addr)
- lkp_gnt_i  in  1  lookup accepted; hit/dirty/unique are valid in the same cycle
- lkp_hit_i, lkp_dirty_i, lkp_unique_i  in  1 each  line state
- rd_req_o  out  1  line data read request
- rd_beat_o  out  $clog2(LineBeats) (min 1)  beat index
- rd_data_i  in  DataWidth  beat data, combinational from rd_beat_o
- upd_valid_o  out  1  one-cycle state-update pulse
- upd_inval_o, upd_clr_dirty_o, upd_clr_unique_o  out  1 each  update actions, valid with upd_valid_o

Behaviour:
- Reset: all outputs 0 and FSM in IDLE; ac_ready is 0 during reset.
- Reset asserted mid-transaction aborts it: no upd pulse, all valids drop the next cycle.
- IDLE: ac_ready=1. On ac_valid, capture ac into a holding register and go to LOOKUP. Latency AC-handshake to CR valid is at least 2 cycles.
- LOOKUP: lkp_req_o=1 until lkp_gnt_i. In the grant cycle, register the hit/dirty/unique flags and the decoded response, then go to RESP.
- RESP: cr_valid=1, cr_resp held stable until cr_ready.
  - On cr_ready, if DataTransfer=1 go to DATA.
  - Otherwise pulse upd (if any action bit is set) and go to IDLE.
- DATA: rd_req_o=1, cd_valid=1, cd.data=rd_data_i. Beat counter starts at 0 and increments on cd_ready. cd.last=1 when the counter equals LineBeats-1.
  - On the last beat handshake: pulse upd, go to IDLE, counter returns to 0.
  - LineBeats=1 means a single beat with last=1.
- cr_resp bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- Miss (any snoop type): cr_resp=0, no data, no update.
- Hit decode by ac.snoop:
  - 0000 ReadOnce: DT=1, IsShared=1, WasUnique=unique, PassDirty=0; no update.
  - 0001 ReadShared, 0011 ReadNotSharedDirty: DT=1, IsShared=1, WasUnique=unique, PassDirty=dirty; update clr_unique=1, clr_dirty=dirty.
  - 0010 ReadClean: DT=1, IsShared=1, WasUnique=unique, PassDirty=0; update clr_unique=1.
  - 0111 ReadUnique: DT=1, PassDirty=dirty, WasUnique=unique; update inval=1.
  - 1000 CleanShared: DT=dirty, PassDirty=dirty, IsShared=1; update clr_dirty=dirty.
  - 1001 CleanInvalid: DT=dirty, PassDirty=dirty, WasUnique=unique; update inval=1.
  - 1101 MakeInvalid: DT=0, WasUnique=unique; update inval=1.
  - Any other code: see Optional Feature.
- Simultaneous events: a new ac_valid while busy is not accepted (ac_ready=0). The upd pulse never overlaps lkp_req_o.

Optional Feature:
- Macro ACE_SNOOP_ERR_EN.
- Defined: an unsupported snoop code answers cr_resp=5'b00010 (Error), no data, no update.
- Undefined: an unsupported code answers cr_resp=0, no data, no update.
- In both cases the lookup is still performed.

Decomposition:
- Package ace_snoop_pkg holds:
  - snoop opcode localparams
  - cr_resp bit-index constants
  - a packed snoop_decision_t {dt, pass_dirty, is_shared, was_unique, err, inval, clr_dirty, clr_unique}
- One sub-module, ace_snoop_decode: a purely combinational function (snoop code, hit, dirty, unique) -> snoop_decision_t, so it can be unit-tested exhaustively.

Test Plan:
- ReadShared to 0x1000, line hit+dirty+unique, LineBeats=4, cr_ready/cd_ready held high -> cr_resp=5'b11101, 4 CD beats with last on beat 3, one upd pulse with clr_unique=1, clr_dirty=1.
- CleanInvalid, hit clean shared -> cr_resp=0, no CD, upd pulse inval=1.
- ReadUnique, miss -> cr_resp=0, no CD, no upd, back in IDLE 1 cycle after cr handshake.
- MakeInvalid, hit unique; cr_ready stalled 5 cycles -> cr_valid and cr_resp=5'b10000 stable throughout, upd inval=1 after handshake.
- ReadOnce hit dirty; cd_ready toggling 1,0,1,0 -> data beats not skipped or repeated, no upd; ac_valid during DATA is not accepted.
- Reset asserted during beat 2 of DATA -> next cycle all valids 0, no upd pulse. Snoop code 0101 -> cr_resp=5'b00010 with ACE_SNOOP_ERR_EN defined, 0 without.

Source files
------------

// File: rtl/ace_snoop_pkg.sv
// Shared types and constants for the ACE snoop responder slice:
// opcodes, CR response bit positions, channel structs and the decode result.
package ace_snoop_pkg;

    localparam int unsigned ACE_ADDR_W = 64;
    localparam int unsigned ACE_DATA_W = 64;

    // Supported AC snoop opcodes
    localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

    // CR response bit positions
    localparam int unsigned CR_DT  = 0;
    localparam int unsigned CR_ERR = 1;
    localparam int unsigned CR_PD  = 2;
    localparam int unsigned CR_IS  = 3;
    localparam int unsigned CR_WU  = 4;

    typedef struct packed {
        logic dt;
        logic pass_dirty;
        logic is_shared;
        logic was_unique;
        logic err;
        logic inval;
        logic clr_dirty;
        logic clr_unique;
    } snoop_decision_t;

    typedef struct packed {
        logic [ACE_ADDR_W-1:0] addr;
        logic [2:0]            prot;
        logic [3:0]            snoop;
    } ac_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic [ACE_DATA_W-1:0] data;
        logic                  last;
    } cd_chan_t;

    typedef struct packed {
        logic       ac_ready;
        logic       cr_valid;
        logic [4:0] cr_resp;
        logic       cd_valid;
        cd_chan_t   cd;
    } snoop_resp_t;

    // Pack a decision into the 5-bit CR response
    function automatic logic [4:0] cr_resp_of(input snoop_decision_t d);
        logic [4:0] r;
        r         = 5'b00000;
        r[CR_DT]  = d.dt;
        r[CR_ERR] = d.err;
        r[CR_PD]  = d.pass_dirty;
        r[CR_IS]  = d.is_shared;
        r[CR_WU]  = d.was_unique;
        return r;
    endfunction

    // True when the decision carries any cache state change
    function automatic logic has_update(input snoop_decision_t d);
        return d.inval | d.clr_dirty | d.clr_unique;
    endfunction

endpackage

// File: rtl/ace_snoop_decode.sv
// Combinational snoop decode: (opcode, hit, dirty, unique) -> CR bits and
// cache update actions. Unsupported opcodes answer Error when ACE_SNOOP_ERR_EN
// is defined, otherwise an all-zero response.
module ace_snoop_decode
    import ace_snoop_pkg::*;
(
    input  logic [3:0]      snoop,
    input  logic            hit,
    input  logic            dirty,
    input  logic            uniq,
    output snoop_decision_t decision
);

    // Map opcode and line state to response bits and update actions; a miss answers all-zero
    always_comb begin
        decision = '0;
        if (hit) begin
            case (snoop)
                SNP_READ_ONCE: begin
                    decision.dt         = 1'b1;
                    decision.is_shared  = 1'b1;
                    decision.was_unique = uniq;
                end
                SNP_READ_SHARED, SNP_READ_NSD: begin
                    decision.dt         = 1'b1;
                    decision.is_shared  = 1'b1;
                    decision.was_unique = uniq;
                    decision.pass_dirty = dirty;
                    decision.clr_unique = 1'b1;
                    decision.clr_dirty  = dirty;
                end
                SNP_READ_CLEAN: begin
                    decision.dt         = 1'b1;
                    decision.is_shared  = 1'b1;
                    decision.was_unique = uniq;
                    decision.clr_unique = 1'b1;
                end
                SNP_READ_UNIQUE: begin
                    decision.dt         = 1'b1;
                    decision.pass_dirty = dirty;
                    decision.was_unique = uniq;
                    decision.inval      = 1'b1;
                end
                SNP_CLEAN_SHARED: begin
                    decision.dt         = dirty;
                    decision.pass_dirty = dirty;
                    decision.is_shared  = 1'b1;
                    decision.clr_dirty  = dirty;
                end
                SNP_CLEAN_INVALID: begin
                    decision.dt         = dirty;
                    decision.pass_dirty = dirty;
                    decision.was_unique = uniq;
                    decision.inval      = 1'b1;
                end
                SNP_MAKE_INVALID: begin
                    decision.was_unique = uniq;
                    decision.inval      = 1'b1;
                end
                default: begin
`ifdef ACE_SNOOP_ERR_EN
                    decision.err = 1'b1;
`else
                    decision.err = 1'b0;
`endif
                end
            endcase
        end else begin
            decision = '0;
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop at a time, looks the line up in
// the local cache, answers on CR, streams the line on CD when DataTransfer is
// set, then issues a single state-update pulse. Optional: ACE_SNOOP_ERR_EN
// makes unsupported opcodes answer with the Error bit.
module ace_snoop_responder
    import ace_snoop_pkg::*;
#(
    parameter  int unsigned AddrWidth = ACE_ADDR_W,
    parameter  int unsigned DataWidth = ACE_DATA_W,
    parameter  int unsigned LineBeats = 4,
    localparam int unsigned BeatW     = (LineBeats > 1) ? $clog2(LineBeats) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  snoop_req_t           snoop_req_i,
    output snoop_resp_t          snoop_resp_o,
    output logic                 lkp_req_o,
    output logic [AddrWidth-1:0] lkp_addr_o,
    input  logic                 lkp_gnt_i,
    input  logic                 lkp_hit_i,
    input  logic                 lkp_dirty_i,
    input  logic                 lkp_unique_i,
    output logic                 rd_req_o,
    output logic [BeatW-1:0]     rd_beat_o,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 upd_valid_o,
    output logic                 upd_inval_o,
    output logic                 upd_clr_dirty_o,
    output logic                 upd_clr_unique_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_RESP, ST_DATA} state_t;

    localparam logic [BeatW-1:0] LAST_BEAT = BeatW'(LineBeats - 1);

    state_t                 state_r;
    logic                   ac_ready_r;
    logic                   lkp_req_r;
    logic                   cr_valid_r;
    logic [4:0]             cr_resp_r;
    logic                   cd_valid_r;
    logic                   rd_req_r;
    logic [BeatW-1:0]       beat_r;
    logic [AddrWidth-1:0]   addr_r;
    logic [3:0]             snoop_r;
    snoop_decision_t        dec_r;
    logic                   upd_valid_r;
    logic                   upd_inval_r;
    logic                   upd_clr_dirty_r;
    logic                   upd_clr_unique_r;
    snoop_decision_t        dec_s;
    snoop_resp_t            resp_s;
    logic                   unused_prot_s;

    assign unused_prot_s = ^snoop_req_i.ac.prot;

    ace_snoop_decode u_decode (
        .snoop    (snoop_r),
        .hit      (lkp_hit_i),
        .dirty    (lkp_dirty_i),
        .uniq     (lkp_unique_i),
        .decision (dec_s)
    );

    // Snoop sequencing FSM with all handshake and update outputs registered
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r          <= ST_IDLE;
            ac_ready_r       <= 1'b0;
            lkp_req_r        <= 1'b0;
            cr_valid_r       <= 1'b0;
            cr_resp_r        <= 5'b00000;
            cd_valid_r       <= 1'b0;
            rd_req_r         <= 1'b0;
            beat_r           <= '0;
            addr_r           <= '0;
            snoop_r          <= 4'b0000;
            dec_r            <= '0;
            upd_valid_r      <= 1'b0;
            upd_inval_r      <= 1'b0;
            upd_clr_dirty_r  <= 1'b0;
            upd_clr_unique_r <= 1'b0;
        end else begin
            upd_valid_r      <= 1'b0;
            upd_inval_r      <= 1'b0;
            upd_clr_dirty_r  <= 1'b0;
            upd_clr_unique_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ac_ready_r && snoop_req_i.ac_valid) begin
                        addr_r     <= snoop_req_i.ac.addr[AddrWidth-1:0];
                        snoop_r    <= snoop_req_i.ac.snoop;
                        ac_ready_r <= 1'b0;
                        lkp_req_r  <= 1'b1;
                        state_r    <= ST_LOOKUP;
                    end else begin
                        ac_ready_r <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    if (lkp_gnt_i) begin
                        dec_r      <= dec_s;
                        cr_resp_r  <= cr_resp_of(dec_s);
                        lkp_req_r  <= 1'b0;
                        cr_valid_r <= 1'b1;
                        state_r    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (snoop_req_i.cr_ready) begin
                        cr_valid_r <= 1'b0;
                        if (dec_r.dt) begin
                            cd_valid_r <= 1'b1;
                            rd_req_r   <= 1'b1;
                            beat_r     <= '0;
                            state_r    <= ST_DATA;
                        end else begin
                            upd_valid_r      <= has_update(dec_r);
                            upd_inval_r      <= dec_r.inval;
                            upd_clr_dirty_r  <= dec_r.clr_dirty;
                            upd_clr_unique_r <= dec_r.clr_unique;
                            ac_ready_r       <= 1'b1;
                            state_r          <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (snoop_req_i.cd_ready) begin
                        if (beat_r == LAST_BEAT) begin
                            cd_valid_r       <= 1'b0;
                            rd_req_r         <= 1'b0;
                            beat_r           <= '0;
                            upd_valid_r      <= has_update(dec_r);
                            upd_inval_r      <= dec_r.inval;
                            upd_clr_dirty_r  <= dec_r.clr_dirty;
                            upd_clr_unique_r <= dec_r.clr_unique;
                            ac_ready_r       <= 1'b1;
                            state_r          <= ST_IDLE;
                        end else begin
                            beat_r <= beat_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ac_ready_r <= 1'b0;
                    lkp_req_r  <= 1'b0;
                    cr_valid_r <= 1'b0;
                    cd_valid_r <= 1'b0;
                    rd_req_r   <= 1'b0;
                    beat_r     <= '0;
                end
            endcase
        end
    end

    // Assemble the response struct; CD data is forced to zero outside a beat
    always_comb begin
        resp_s          = '0;
        resp_s.ac_ready = ac_ready_r;
        resp_s.cr_valid = cr_valid_r;
        resp_s.cr_resp  = cr_resp_r;
        resp_s.cd_valid = cd_valid_r;
        resp_s.cd.last  = cd_valid_r && (beat_r == LAST_BEAT);
        if (cd_valid_r) begin
            resp_s.cd.data = ACE_DATA_W'(rd_data_i);
        end else begin
            resp_s.cd.data = '0;
        end
    end

    assign snoop_resp_o     = resp_s;
    assign lkp_req_o        = lkp_req_r;
    assign lkp_addr_o       = addr_r;
    assign rd_req_o         = rd_req_r;
    assign rd_beat_o        = beat_r;
    assign upd_valid_o      = upd_valid_r;
    assign upd_inval_o      = upd_inval_r;
    assign upd_clr_dirty_o  = upd_clr_dirty_r;
    assign upd_clr_unique_o = upd_clr_unique_r;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed scoreboard bench for ace_snoop_responder (LineBeats = 4).
module tb_ace_snoop_responder;
    import ace_snoop_pkg::*;

    logic        clk;
    logic        rst_n;
    snoop_req_t  req;
    snoop_resp_t resp;
    logic        lkp_req;
    logic [63:0] lkp_addr;
    logic        lkp_gnt;
    logic        lkp_seen;
    logic        hit, dirty, uniq;
    logic        rd_req;
    logic [1:0]  rd_beat;
    logic [63:0] rd_data;
    logic        upd_valid, upd_inval, upd_clr_dirty, upd_clr_unique;

    logic [4:0]  cr_q[$];
    logic [64:0] cd_q[$];
    logic [2:0]  upd_q[$];
    logic [63:0] cur_addr;
    int          passed;
    int          failed;
    int          total;
    int          upd_seen;

    ace_snoop_responder #(.AddrWidth(64), .DataWidth(64), .LineBeats(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .snoop_req_i      (req),
        .snoop_resp_o     (resp),
        .lkp_req_o        (lkp_req),
        .lkp_addr_o       (lkp_addr),
        .lkp_gnt_i        (lkp_gnt),
        .lkp_hit_i        (hit),
        .lkp_dirty_i      (dirty),
        .lkp_unique_i     (uniq),
        .rd_req_o         (rd_req),
        .rd_beat_o        (rd_beat),
        .rd_data_i        (rd_data),
        .upd_valid_o      (upd_valid),
        .upd_inval_o      (upd_inval),
        .upd_clr_dirty_o  (upd_clr_dirty),
        .upd_clr_unique_o (upd_clr_unique)
    );

    function automatic logic [63:0] mem_word(input logic [63:0] a, input int beat);
        return {a[31:0], 24'hDA7A00, 8'(beat)};
    endfunction

    // Cache model: grant on the second lookup cycle, line data keyed by address and beat
    always @(posedge clk) lkp_seen <= lkp_req;
    assign lkp_gnt = lkp_req & lkp_seen;
    assign rd_data = mem_word(lkp_addr, int'(rd_beat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cd(input logic [63:0] a, input int n);
        for (int i = 0; i < n; i++) cd_q.push_back({(i == 3), mem_word(a, i)});
    endtask

    task automatic send_ac(input logic [63:0] a, input logic [3:0] s);
        int n;
        n = 0;
        @(negedge clk);
        req.ac_valid   = 1'b1;
        req.ac.addr    = a;
        req.ac.snoop   = s;
        req.ac.prot    = 3'b000;
        cur_addr       = a;
        while (!resp.ac_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ac_accept", 64'(resp.ac_ready), 64'd1);
        @(negedge clk);
        req.ac_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!resp.ac_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(resp.ac_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cr();
        int n;
        n = 0;
        while (!resp.cr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cr_timeout", 64'(resp.cr_valid), 64'd1);
    endtask

    // Monitor: pops the scoreboard on every CR/CD handshake and update pulse
    initial forever begin
        @(negedge clk);
        #2;
        if (lkp_req) chk("lkp_addr", lkp_addr, cur_addr);
        if (resp.cr_valid && req.cr_ready) begin
            if (cr_q.size() == 0) chk("cr_unexpected", 64'(cr_q.size()), 64'd1);
            else chk("cr_resp", 64'(resp.cr_resp), 64'(cr_q.pop_front()));
        end
        if (resp.cd_valid && req.cd_ready) begin
            if (cd_q.size() == 0) chk("cd_unexpected", 64'(cd_q.size()), 64'd1);
            else begin
                logic [64:0] e;
                e = cd_q.pop_front();
                chk("cd_data", resp.cd.data, e[63:0]);
                chk("cd_last", 64'(resp.cd.last), 64'(e[64]));
            end
        end
        if (upd_valid) begin
            upd_seen++;
            if (upd_q.size() == 0) chk("upd_unexpected", 64'(upd_q.size()), 64'd1);
            else chk("upd_bits", 64'({upd_inval, upd_clr_dirty, upd_clr_unique}), 64'(upd_q.pop_front()));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int dc;
        int n;
        passed = 0; failed = 0; total = 0; upd_seen = 0;
        rst_n = 1'b0;
        req = '0;
        hit = 1'b0; dirty = 1'b0; uniq = 1'b0;
        cur_addr = 64'h0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({resp.ac_ready, resp.cr_valid, resp.cd_valid, lkp_req, rd_req,
                               upd_valid, upd_inval, upd_clr_dirty, upd_clr_unique, resp.cr_resp, resp.cd.last}), 64'd0);
        chk("reset_cd_data", resp.cd.data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(resp.ac_ready), 64'd1);

        // ReadShared hit dirty unique, readies high
        req.cr_ready = 1'b1; req.cd_ready = 1'b1;
        hit = 1'b1; dirty = 1'b1; uniq = 1'b1;
        cr_q.push_back(5'b11101); push_cd(64'h1000, 4); upd_q.push_back(3'b011);
        s0 = upd_seen;
        send_ac(64'h1000, SNP_READ_SHARED);
        wait_idle();
        chk("rs_upd_count", 64'(upd_seen - s0), 64'd1);

        // CleanInvalid hit clean shared
        hit = 1'b1; dirty = 1'b0; uniq = 1'b0;
        cr_q.push_back(5'b00000); upd_q.push_back(3'b100);
        s0 = upd_seen;
        send_ac(64'h2040, SNP_CLEAN_INVALID);
        wait_idle();
        chk("ci_upd_count", 64'(upd_seen - s0), 64'd1);

        // ReadUnique miss: idle one cycle after the CR handshake
        hit = 1'b0; dirty = 1'b1; uniq = 1'b1;
        cr_q.push_back(5'b00000);
        s0 = upd_seen;
        send_ac(64'h3080, SNP_READ_UNIQUE);
        wait_cr();
        @(negedge clk);
        chk("ru_idle_next", 64'(resp.ac_ready), 64'd1);
        wait_idle();
        chk("ru_upd_count", 64'(upd_seen - s0), 64'd0);

        // MakeInvalid hit unique with CR stalled for five cycles
        hit = 1'b1; dirty = 1'b0; uniq = 1'b1;
        req.cr_ready = 1'b0;
        cr_q.push_back(5'b10000); upd_q.push_back(3'b100);
        s0 = upd_seen;
        send_ac(64'h40C0, SNP_MAKE_INVALID);
        wait_cr();
        for (int i = 0; i < 5; i++) begin
            chk("mi_stall_valid", 64'(resp.cr_valid), 64'd1);
            chk("mi_stall_resp", 64'(resp.cr_resp), 64'h10);
            @(negedge clk);
        end
        req.cr_ready = 1'b1;
        wait_idle();
        chk("mi_upd_count", 64'(upd_seen - s0), 64'd1);

        // ReadOnce hit dirty, cd_ready toggling, AC offered while busy
        hit = 1'b1; dirty = 1'b1; uniq = 1'b0;
        req.cd_ready = 1'b0;
        cr_q.push_back(5'b01001); push_cd(64'h5100, 4);
        s0 = upd_seen;
        send_ac(64'h5100, SNP_READ_ONCE);
        dc = 0; n = 0;
        while (!resp.ac_ready && n < 60) begin
            req.cd_ready = (n % 2 == 0);
            if (resp.cd_valid && dc < 2) begin
                req.ac_valid = 1'b1;
                req.ac.addr  = 64'h9999_0000;
                chk("ro_ac_busy", 64'(resp.ac_ready), 64'd0);
                dc++;
            end else begin
                req.ac_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        req.ac_valid = 1'b0;
        req.cd_ready = 1'b1;
        wait_idle();
        chk("ro_no_new_lookup", 64'({lkp_req, resp.cr_valid}), 64'd0);
        chk("ro_upd_count", 64'(upd_seen - s0), 64'd0);

        // Reset during beat 2 of ReadShared aborts the transaction
        hit = 1'b1; dirty = 1'b1; uniq = 1'b1;
        cr_q.push_back(5'b11101); push_cd(64'h6200, 3);
        s0 = upd_seen;
        send_ac(64'h6200, SNP_READ_SHARED);
        n = 0;
        while (!(resp.cd_valid && rd_beat == 2'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_beat2_seen", 64'(rd_beat), 64'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs", 64'({resp.ac_ready, resp.cr_valid, resp.cd_valid, lkp_req, rd_req, upd_valid}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_upd_count", 64'(upd_seen - s0), 64'd0);

        // Unsupported opcode 0101 on a hit
        hit = 1'b1; dirty = 1'b0; uniq = 1'b0;
`ifdef ACE_SNOOP_ERR_EN
        cr_q.push_back(5'b00010);
`else
        cr_q.push_back(5'b00000);
`endif
        s0 = upd_seen;
        send_ac(64'h7300, 4'b0101);
        wait_idle();
        chk("bad_upd_count", 64'(upd_seen - s0), 64'd0);

        chk("cr_q_empty", 64'(cr_q.size()), 64'd0);
        chk("cd_q_empty", 64'(cd_q.size()), 64'd0);
        chk("upd_q_empty", 64'(upd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
